// File: rtl/bram_arbiter_pkg.sv
// Shared types for the two-master block-RAM arbiter.
package bram_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} bram_arb_state_t;

  typedef logic master_sel_t;

  localparam master_sel_t SEL_M0 = 1'b0;
  localparam master_sel_t SEL_M1 = 1'b1;

endpackage

// File: rtl/bram_arbiter_pick.sv
// Winner select between the two masters.
// BRAM_ARBITER_ROUND_ROBIN_EN: ties go to the master not granted last time; otherwise m0 always wins.
module bram_arbiter_pick
  import bram_arbiter_pkg::*;
(
  input  logic        req0,
  input  logic        req1,
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
  input  master_sel_t last,
`endif
  output logic        any,
  output master_sel_t sel
);

  always_comb begin
    any = req0 | req1;
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
    if (req0 && req1) begin
      sel = ~last;
    end else begin
      sel = req0 ? SEL_M0 : SEL_M1;
    end
`else
    sel = req0 ? SEL_M0 : SEL_M1;
`endif
  end

endmodule

// File: rtl/bram_arbiter.sv
// Serialises two masters onto one single-port block RAM and steers responses back.
// BRAM_ARBITER_ROUND_ROBIN_EN selects round-robin tie breaking (default: fixed priority to m0).
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_m0_request,
  input  logic              i_m0_rw,
  input  logic [ADDR_W-1:0] i_m0_address,
  input  logic [WIDTH-1:0]  i_m0_wdata,
  output logic [WIDTH-1:0]  o_m0_rdata,
  output logic              o_m0_ready,
  output logic              o_m0_valid,
  input  logic              i_m1_request,
  input  logic              i_m1_rw,
  input  logic [ADDR_W-1:0] i_m1_address,
  input  logic [WIDTH-1:0]  i_m1_wdata,
  output logic [WIDTH-1:0]  o_m1_rdata,
  output logic              o_m1_ready,
  output logic              o_m1_valid,
  output logic              o_request,
  output logic              o_rw,
  output logic [ADDR_W-1:0] o_address,
  output logic [WIDTH-1:0]  o_wdata,
  input  logic [WIDTH-1:0]  i_rdata,
  input  logic              i_ready,
  input  logic              i_valid
);

  bram_arb_state_t state;
  master_sel_t     grant;
  master_sel_t     sel;
  logic            any;

`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
  master_sel_t     last;
`endif

  bram_arbiter_pick u_pick (
    .req0 (i_m0_request),
    .req1 (i_m1_request),
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
    .last (last),
`endif
    .any  (any),
    .sel  (sel)
  );

  // Command regs are latched in IDLE only, so later master changes are ignored.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      grant      <= SEL_M0;
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
      last       <= SEL_M1;
`endif
      o_request  <= 1'b0;
      o_rw       <= 1'b0;
      o_address  <= '0;
      o_wdata    <= '0;
      o_m0_rdata <= '0;
      o_m0_ready <= 1'b0;
      o_m0_valid <= 1'b1;
      o_m1_rdata <= '0;
      o_m1_ready <= 1'b0;
      o_m1_valid <= 1'b1;
    end else begin
      o_request  <= 1'b0;
      o_m0_ready <= 1'b0;
      o_m1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            grant     <= sel;
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
            last      <= sel;
`endif
            o_rw      <= (sel == SEL_M1) ? i_m1_rw      : i_m0_rw;
            o_address <= (sel == SEL_M1) ? i_m1_address : i_m0_address;
            o_wdata   <= (sel == SEL_M1) ? i_m1_wdata   : i_m0_wdata;
            o_request <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (i_ready) begin
            if (grant == SEL_M1) begin
              if (!o_rw) o_m1_rdata <= i_rdata;
              o_m1_valid <= i_valid;
              o_m1_ready <= 1'b1;
            end else begin
              if (!o_rw) o_m0_rdata <= i_rdata;
              o_m0_valid <= i_valid;
              o_m0_ready <= 1'b1;
            end
            state <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: single-master vector table plus contention/reset/spurious sequences.
module tb_bram_arbiter;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          m0_req, m0_rw, m1_req, m1_rw;
  logic [31:0]   m0_addr, m1_addr;
  logic [W-1:0]  m0_wdata, m1_wdata;
  logic [W-1:0]  o_m0_rdata, o_m1_rdata;
  logic          o_m0_ready, o_m0_valid, o_m1_ready, o_m1_valid;
  logic          o_request, o_rw;
  logic [31:0]   o_address;
  logic [W-1:0]  o_wdata;
  logic [W-1:0]  ram_rdata;
  logic          ram_ready, ram_valid, i_ready;
  logic          ram_hold, inject, preload;

  logic [31:0]   mem [0:255];

  always #5 clk = ~clk;

  bram_arbiter #(.WIDTH(W)) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_m0_request (m0_req),
    .i_m0_rw      (m0_rw),
    .i_m0_address (m0_addr),
    .i_m0_wdata   (m0_wdata),
    .o_m0_rdata   (o_m0_rdata),
    .o_m0_ready   (o_m0_ready),
    .o_m0_valid   (o_m0_valid),
    .i_m1_request (m1_req),
    .i_m1_rw      (m1_rw),
    .i_m1_address (m1_addr),
    .i_m1_wdata   (m1_wdata),
    .o_m1_rdata   (o_m1_rdata),
    .o_m1_ready   (o_m1_ready),
    .o_m1_valid   (o_m1_valid),
    .o_request    (o_request),
    .o_rw         (o_rw),
    .o_address    (o_address),
    .o_wdata      (o_wdata),
    .i_rdata      (ram_rdata),
    .i_ready      (i_ready),
    .i_valid      (ram_valid)
  );

  // RAM model: answers one cycle after o_request; addresses >= 0x4000_0000 are out of range.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'hDEAD0000;
      mem[4]    <= 32'hCAFE0001;
      ram_ready <= 1'b0;
      ram_rdata <= '0;
      ram_valid <= 1'b0;
    end else begin
      ram_ready <= o_request & ~ram_hold;
      if (o_request) begin
        ram_rdata <= mem[o_address[9:2]];
        ram_valid <= (o_address < 32'h4000_0000);
        if (o_rw) mem[o_address[9:2]] <= o_wdata;
      end
    end
  end

  assign i_ready = ram_ready | inject;

  int checks = 0;
  int errors = 0;
  logic [31:0] mrd [2];
  logic        mvl [2];

  typedef struct {
    int          m;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_vl;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic req, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_rw = rw; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_rw = rw; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 0) ? o_m0_ready : o_m1_ready;
  endfunction

  function automatic logic [31:0] rdata_of(input int m);
    return (m == 0) ? o_m0_rdata : o_m1_rdata;
  endfunction

  function automatic logic valid_of(input int m);
    return (m == 0) ? o_m0_valid : o_m1_valid;
  endfunction

  task automatic do_reset();
    i_reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    i_reset = 1'b0;
    mrd[0] = 32'h0; mrd[1] = 32'h0;
    mvl[0] = 1'b1;  mvl[1] = 1'b1;
  endtask

  // One uncontended access; starts in an IDLE cycle and returns in an IDLE cycle.
  task automatic do_txn(input int m, input logic rw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_vl, input string name);
    int n;
    bit seen;
    int o;
    o = 1 - m;
    drive(m, 1'b1, rw, addr, wdata);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      chk({name, "_other_ready"}, 32'(rdy(o)), 32'h0);
      if (n == 1) begin
        chk({name, "_req_pulse"}, 32'(o_request), 32'h1);
        chk({name, "_addr"}, o_address, addr);
        drive(m, 1'b1, ~rw, ~addr, ~wdata);
      end else if (n == 2) begin
        chk({name, "_req_drop"}, 32'(o_request), 32'h0);
        chk({name, "_addr_hold"}, o_address, addr);
      end
      if (rdy(m)) seen = 1;
    end
    chk({name, "_latency"}, 32'(n), 32'd3);
    if (!rw) mrd[m] = exp_rd;
    mvl[m] = exp_vl;
    chk({name, "_rdata"}, rdata_of(m), mrd[m]);
    chk({name, "_valid"}, 32'(valid_of(m)), 32'(mvl[m]));
    chk({name, "_other_rdata"}, rdata_of(o), mrd[o]);
    chk({name, "_other_valid"}, 32'(valid_of(o)), 32'(mvl[o]));
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk({name, "_ready_once"}, 32'(rdy(m)), 32'h0);
  endtask

  initial begin
    int k;
    int cyc;
    int done0, done1;
    int exp_m;

    vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE0001, 1'b1};
    vecs[1] = '{1, 1'b1, 32'h0000_0020, 32'h12345678,  32'h0,        1'b1};
    vecs[2] = '{1, 1'b0, 32'h0000_0020, 32'h0,         32'h12345678, 1'b1};
    vecs[3] = '{0, 1'b0, 32'h4000_0000, 32'h0,         32'hDEAD0000, 1'b0};
    vecs[4] = '{0, 1'b1, 32'h0000_0014, 32'hA5A5A5A5,  32'h0,        1'b1};
    vecs[5] = '{1, 1'b0, 32'h0000_0014, 32'h0,         32'hA5A5A5A5, 1'b1};
    vecs[6] = '{1, 1'b0, 32'h7FFF_FFFC, 32'h0,         32'h0,        1'b0};
    vecs[7] = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE0001, 1'b1};

    ram_hold = 1'b0;
    inject   = 1'b0;
    preload  = 1'b1;
    do_reset();
    preload  = 1'b0;

    chk("rst_request", 32'(o_request), 32'h0);
    chk("rst_rw",      32'(o_rw),      32'h0);
    chk("rst_address", o_address,      32'h0);
    chk("rst_wdata",   o_wdata,        32'h0);
    chk("rst_m0_ready", 32'(o_m0_ready), 32'h0);
    chk("rst_m1_ready", 32'(o_m1_ready), 32'h0);
    chk("rst_m0_rdata", o_m0_rdata,      32'h0);
    chk("rst_m1_rdata", o_m1_rdata,      32'h0);
    chk("rst_m0_valid", 32'(o_m0_valid), 32'h1);
    chk("rst_m1_valid", 32'(o_m1_valid), 32'h1);

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].m, vecs[i].rw, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rd, vecs[i].exp_vl, $sformatf("vec%0d", i));
    end

    // Reset while WAIT is stalled by the RAM; a late i_ready must not ack.
    ram_hold = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    tick();
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    mrd[0] = 32'h0; mrd[1] = 32'h0;
    mvl[0] = 1'b1;  mvl[1] = 1'b1;
    chk("rstw_m0_ready", 32'(o_m0_ready), 32'h0);
    chk("rstw_m1_ready", 32'(o_m1_ready), 32'h0);
    chk("rstw_request",  32'(o_request),  32'h0);
    chk("rstw_m0_rdata", o_m0_rdata,      32'h0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rstw_late_ready", 32'(o_m0_ready | o_m1_ready), 32'h0);
      chk("rstw_late_req",   32'(o_request),               32'h0);
      tick();
    end
    ram_hold = 1'b0;
    do_txn(1, 1'b0, 32'h0000_0020, 32'h0, 32'h12345678, 1'b1, "post_rst");

    // Spurious i_ready in IDLE.
    inject = 1'b1;
    tick();
    inject = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("spur_ready", 32'(o_m0_ready | o_m1_ready), 32'h0);
      chk("spur_req",   32'(o_request),               32'h0);
      tick();
    end
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE0001, 1'b1, "post_spur");

    // Both masters hold requests for four accesses each.
    do_reset();
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
    k = 0; cyc = 0; done0 = 0; done1 = 0;
    while (k < 8 && cyc < 100) begin
      tick();
      cyc++;
      chk("cont_both_ready", 32'(o_m0_ready & o_m1_ready), 32'h0);
      if (o_m0_ready || o_m1_ready) begin
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
        exp_m = k % 2;
`else
        exp_m = (k < 4) ? 0 : 1;
`endif
        chk($sformatf("cont_grant%0d", k), 32'(o_m1_ready), 32'(exp_m));
        chk($sformatf("cont_cycle%0d", k), 32'(cyc), 32'(3 + 4 * k));
        if (o_m0_ready) begin
          done0++;
          if (done0 == 4) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        end else begin
          done1++;
          if (done1 == 4) drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        k++;
      end
    end
    chk("cont_count", 32'(k), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
